neopixel_layer_conf: RTL and testbench
======================================

// Module: neopixel_layer_conf
// PURPOSE
//  - Bit-timing configuration register bank for the NeoPixel (WS281x) serial output layer.
//  - Holds four 8-bit clock-cycle counts: T0H, T0L, T1H, T1L.
//  - The bit encoder consumes these counts to shape each '0' and '1' symbol.
//  - Written by the host-side command decoder through a simple byte-wide write port.
// PARAMETERS
//  - ADDR_W   6      write/read address width
//  - DATA_W   8      register/count width
//  - T0H_DEF  8'd16  T0H reset value (400 ns @ 40 MHz)
//  - T0L_DEF  8'd34  T0L reset value (850 ns @ 40 MHz)
//  - T1H_DEF  8'd32  T1H reset value (800 ns @ 40 MHz)
//  - T1L_DEF  8'd18  T1L reset value (450 ns @ 40 MHz)
// PORTS
//  - clk_in       in   1       single system clock, rising edge
//  - rst_in       in   1       reset, asynchronous assert, active-high
//  - wr_en_in     in   1       write strobe, sampled on clk_in rising edge
//  - wr_addr_in   in   ADDR_W  register address
//  - wr_data_in   in   DATA_W  write data
//  - t0h_cnt_out  out  DATA_W  T0H count
//  - t0l_cnt_out  out  DATA_W  T0L count
//  - t1h_cnt_out  out  DATA_W  T1H count
//  - t1l_cnt_out  out  DATA_W  T1L count
//  - rd_en_in     in   1       read strobe; present only with LAYER_CONF_RDBACK_EN
//  - rd_addr_in   in   ADDR_W  read address; present only with LAYER_CONF_RDBACK_EN
//  - rd_data_out  out  DATA_W  read data; present only with LAYER_CONF_RDBACK_EN
// BEHAVIOUR
//  - Clock and reset:
//    - One clock domain.
//    - rst_in high immediately forces every output to its *_DEF value, independent of the clock.
//    - Release of rst_in is assumed synchronised upstream.
//  - Address map: 0x00 = T0H, 0x01 = T0L, 0x02 = T1H, 0x03 = T1L.
//    - Writes to addresses 0x04..0x3F are ignored; no register changes.
//  - Write timing:
//    - On a rising edge with wr_en_in = 1, the addressed register loads wr_data_in.
//    - The new value is visible on its *_cnt_out port immediately after that edge (1-cycle latency).
//    - wr_en_in = 0 holds all registers.
//  - A single-cycle strobe performs exactly one write.
//    - A strobe held N cycles rewrites the same data N times, with no side effects.
//  - Outputs are driven directly from flops (no combinational path from inputs).
//  - Every value 0x00..0xFF is accepted verbatim, with no clamping.
//    - Keeping the counts nonzero is the consumer's responsibility.
//  - rst_in asserted in the same cycle as a write: reset wins and the write is lost.
//  - No handshake and no busy state.
// CONFIGURATION
//  - Macro LAYER_CONF_RDBACK_EN enables readback.
//  - Defined:
//    - rd_data_out is registered and valid 1 cycle after a rising edge with rd_en_in = 1.
//    - It returns the addressed register; unmapped addresses return 0x00.
//    - rd_data_out holds its value while rd_en_in = 0 and resets to 0x00.
//    - Read and write of the same address in the same cycle returns the OLD value.
//  - Undefined: the rd_* ports are absent; the rest of the behaviour is identical.
// STRUCTURE
//  - Package layer_conf_pkg holds:
//    - ADDR_T0H/ADDR_T0L/ADDR_T1H/ADDR_T1L constants (6'h00..6'h03)
//    - typedef cnt_t (logic [7:0])
//    - default timing constants
//  - Sub-module conf_reg: one DATA_W register with async active-high reset to a parameter value and a load enable.
//    - Instantiated 4x; each load enable = wr_en_in & (wr_addr_in == ADDR_x).
// TESTING
//  - Reset: assert rst_in mid-cycle with no clock edge -> outputs become 16/34/32/18 immediately.
//  - Write 0x00<-0x01, 0x01<-0x12, 0x02<-0x23, 0x03<-0x34, each as a 1-cycle strobe
//    -> outputs 0x01/0x12/0x23/0x34, each updating the edge after its strobe; others unchanged.
//  - Write 0x04<-0xFF and 0x3F<-0xAA -> all four outputs unchanged.
//  - wr_en_in = 0 with addr 0x00 and data 0x55 for 10 cycles -> t0h_cnt_out unchanged.
//  - After the programmed values, assert rst_in -> all outputs return to defaults.
//    - Assert rst_in together with a write strobe -> write discarded.
//  - With LAYER_CONF_RDBACK_EN: read 0x02 after the 0x23 write -> rd_data_out = 0x23 one cycle later.
//    - Read 0x07 -> 0x00.
//    - Same-cycle read and write of 0x01 -> old value.

Source files
------------

// File: rtl/layer_conf_pkg.sv
// Shared constants and types for the NeoPixel bit-timing configuration bank.
// Holds the register address map, the count type and the power-on timing
// defaults (40 MHz clock).
package layer_conf_pkg;

    typedef logic [7:0] cnt_t;

    localparam logic [5:0] ADDR_T0H = 6'h00;
    localparam logic [5:0] ADDR_T0L = 6'h01;
    localparam logic [5:0] ADDR_T1H = 6'h02;
    localparam logic [5:0] ADDR_T1L = 6'h03;

    localparam cnt_t T0H_DEFAULT = 8'd16;
    localparam cnt_t T0L_DEFAULT = 8'd34;
    localparam cnt_t T1H_DEFAULT = 8'd32;
    localparam cnt_t T1L_DEFAULT = 8'd18;

endpackage

// File: rtl/conf_reg.sv
// One configuration register.
// It has an asynchronous active-high reset to a parameterised value and a
// load enable. The value is held whenever the load enable is low.
module conf_reg #(
    parameter int               DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ld_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] q_out
);

    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;

    // Next value: take the new data on a load, otherwise hold.
    always_comb begin
        value_d = value_q;
        if (ld_in) begin
            value_d = d_in;
        end
    end

    // Storage flop; reset forces the default without waiting for a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign q_out = value_q;

endmodule

// File: rtl/neopixel_layer_conf.sv
// Bit-timing configuration register bank for the NeoPixel (WS281x) output layer.
// It holds four counts (T0H, T0L, T1H, T1L). The host writes them through a
// byte-wide port, and each count drives its output directly from a flop.
// Optional readback port: enabled by defining LAYER_CONF_RDBACK_EN.
module neopixel_layer_conf
    import layer_conf_pkg::*;
#(
    parameter int               ADDR_W  = 6,
    parameter int               DATA_W  = 8,
    parameter logic [DATA_W-1:0] T0H_DEF = 8'd16,
    parameter logic [DATA_W-1:0] T0L_DEF = 8'd34,
    parameter logic [DATA_W-1:0] T1H_DEF = 8'd32,
    parameter logic [DATA_W-1:0] T1L_DEF = 8'd18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
`ifdef LAYER_CONF_RDBACK_EN
    input  logic              rd_en_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic [DATA_W-1:0] rd_data_out,
`endif
    output logic [DATA_W-1:0] t0h_cnt_out,
    output logic [DATA_W-1:0] t0l_cnt_out,
    output logic [DATA_W-1:0] t1h_cnt_out,
    output logic [DATA_W-1:0] t1l_cnt_out
);

    logic ld_t0h;
    logic ld_t0l;
    logic ld_t1h;
    logic ld_t1l;

    // Address decode: unmapped addresses raise no load enable, so they are ignored.
    always_comb begin
        ld_t0h = wr_en_in && (wr_addr_in == ADDR_W'(ADDR_T0H));
        ld_t0l = wr_en_in && (wr_addr_in == ADDR_W'(ADDR_T0L));
        ld_t1h = wr_en_in && (wr_addr_in == ADDR_W'(ADDR_T1H));
        ld_t1l = wr_en_in && (wr_addr_in == ADDR_W'(ADDR_T1L));
    end

    conf_reg #(.DATA_W(DATA_W), .RST_VAL(T0H_DEF)) u_t0h (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .ld_in  (ld_t0h),
        .d_in   (wr_data_in),
        .q_out  (t0h_cnt_out)
    );

    conf_reg #(.DATA_W(DATA_W), .RST_VAL(T0L_DEF)) u_t0l (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .ld_in  (ld_t0l),
        .d_in   (wr_data_in),
        .q_out  (t0l_cnt_out)
    );

    conf_reg #(.DATA_W(DATA_W), .RST_VAL(T1H_DEF)) u_t1h (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .ld_in  (ld_t1h),
        .d_in   (wr_data_in),
        .q_out  (t1h_cnt_out)
    );

    conf_reg #(.DATA_W(DATA_W), .RST_VAL(T1L_DEF)) u_t1l (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .ld_in  (ld_t1l),
        .d_in   (wr_data_in),
        .q_out  (t1l_cnt_out)
    );

`ifdef LAYER_CONF_RDBACK_EN
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read mux: samples the register outputs before this edge's write takes
    // effect, so a same-cycle read of a written address returns the old value.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_in) begin
            if (rd_addr_in == ADDR_W'(ADDR_T0H)) begin
                rd_data_d = t0h_cnt_out;
            end else if (rd_addr_in == ADDR_W'(ADDR_T0L)) begin
                rd_data_d = t0l_cnt_out;
            end else if (rd_addr_in == ADDR_W'(ADDR_T1H)) begin
                rd_data_d = t1h_cnt_out;
            end else if (rd_addr_in == ADDR_W'(ADDR_T1L)) begin
                rd_data_d = t1l_cnt_out;
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // Registered read data; it holds between reads and clears on reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_out = rd_data_q;
`endif

endmodule

// File: tb/tb_neopixel_layer_conf.sv
// Self-checking bench for neopixel_layer_conf.
// A simple array model of the four counts (and the readback register, when
// LAYER_CONF_RDBACK_EN is defined) is compared against the DUT after every edge.
module tb_neopixel_layer_conf;

    logic       clk;
    logic       rst;
    logic       wrEn;
    logic [5:0] wrAddr;
    logic [7:0] wrData;
    logic       rdEn;
    logic [5:0] rdAddr;
    logic [7:0] rdData;
    logic [7:0] t0h;
    logic [7:0] t0l;
    logic [7:0] t1h;
    logic [7:0] t1l;

    logic [7:0] model [4];
    logic [7:0] rdExp;
    int         checks;
    int         errors;

    neopixel_layer_conf dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .wr_en_in    (wrEn),
        .wr_addr_in  (wrAddr),
        .wr_data_in  (wrData),
`ifdef LAYER_CONF_RDBACK_EN
        .rd_en_in    (rdEn),
        .rd_addr_in  (rdAddr),
        .rd_data_out (rdData),
`endif
        .t0h_cnt_out (t0h),
        .t0l_cnt_out (t0l),
        .t1h_cnt_out (t1h),
        .t1l_cnt_out (t1l)
    );

`ifndef LAYER_CONF_RDBACK_EN
    assign rdData = 8'h00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    // Load the reset defaults into the model.
    task automatic modelReset();
        model[0] = 8'd16;
        model[1] = 8'd34;
        model[2] = 8'd32;
        model[3] = 8'd18;
        rdExp    = 8'h00;
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".t0h"}, t0h, model[0]);
        checkOutput({tag, ".t0l"}, t0l, model[1]);
        checkOutput({tag, ".t1h"}, t1h, model[2]);
        checkOutput({tag, ".t1l"}, t1l, model[3]);
`ifdef LAYER_CONF_RDBACK_EN
        checkOutput({tag, ".rd"}, rdData, rdExp);
`endif
    endtask

    // Drive one cycle of inputs and update the model at the clock edge.
    // Then check all outputs just after the edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [5:0] wa,
                                 input logic [7:0] wd, input logic re, input logic [5:0] ra);
        @(negedge clk);
        wrEn   = we;
        wrAddr = wa;
        wrData = wd;
        rdEn   = re;
        rdAddr = ra;
        @(posedge clk);
        if (re) begin
            rdExp = (ra < 6'd4) ? model[ra[1:0]] : 8'h00;
        end
        if (we && (wa < 6'd4)) begin
            model[wa[1:0]] = wd;
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        rdEn   = 1'b0;
        rdAddr = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("wr0", 1'b1, 6'h00, 8'h01, 1'b0, 6'h00);
        applyStimulus("wr1", 1'b1, 6'h01, 8'h12, 1'b0, 6'h00);
        applyStimulus("wr2", 1'b1, 6'h02, 8'h23, 1'b0, 6'h00);
        applyStimulus("wr3", 1'b1, 6'h03, 8'h34, 1'b0, 6'h00);
        applyStimulus("wr04", 1'b1, 6'h04, 8'hFF, 1'b0, 6'h00);
        applyStimulus("wr3F", 1'b1, 6'h3F, 8'hAA, 1'b0, 6'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("hold", 1'b0, 6'h00, 8'h55, 1'b0, 6'h00);
        end
        applyStimulus("rd2", 1'b0, 6'h00, 8'h00, 1'b1, 6'h02);
        applyStimulus("rdhold", 1'b0, 6'h00, 8'h00, 1'b0, 6'h03);
        applyStimulus("rd7", 1'b0, 6'h00, 8'h00, 1'b1, 6'h07);
        applyStimulus("rdwr1", 1'b1, 6'h01, 8'h77, 1'b1, 6'h01);
        applyStimulus("rd1new", 1'b0, 6'h00, 8'h00, 1'b1, 6'h01);
        applyStimulus("wrFF", 1'b1, 6'h02, 8'hFF, 1'b0, 6'h00);
        applyStimulus("wr00", 1'b1, 6'h03, 8'h00, 1'b1, 6'h02);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #2;
        modelReset();
        checkAll("asyncrst");

        // A write strobe coincident with reset must be lost.
        @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = 6'h00;
        wrData = 8'h99;
        @(posedge clk);
        #1;
        checkAll("rstwr");
        @(negedge clk);
        rst  = 1'b0;
        wrEn = 1'b0;

        // Randomized traffic, biased toward the mapped addresses.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] wa;
            logic [5:0] ra;
            wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
            applyStimulus("rand", 1'($urandom_range(0, 1)), wa, 8'($urandom),
                          1'($urandom_range(0, 1)), ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
